// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and the address-fault check for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} dmemState_t;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_LANES = 4;
  localparam int DMEM_CNT_WIDTH = 4;
  function automatic logic addrFault(input logic [31:0] addr, input int addrWidth);
    return (addr[1:0] != 2'b00) || ((addr >> (addrWidth + 2)) != 32'd0);
  endfunction
endpackage

// File: rtl/dmem_storage_array.sv
// dmem_storage_array: word RAM with per-lane synchronous writes and a registered synchronous read
module dmem_storage_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clock,
  input  logic [DMEM_LANES-1:0]      writeEnable,
  input  logic                       readEnable,
  input  logic [ADDR_WIDTH-1:0]      index,
  input  logic [DMEM_DATA_WIDTH-1:0] writeData,
  output logic [DMEM_DATA_WIDTH-1:0] readData
);
  logic [DMEM_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // lane-masked write and registered read; contents deliberately have no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < DMEM_LANES; i++)
      if (writeEnable[i]) mem[index][8*i +: 8] <= writeData[8*i +: 8];
    if (readEnable) readData <= mem[index];
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: MEM-stage memory responder with fixed wait states (DMEM_BYTE_ENABLE_EN adds lane enables)
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       request_valid,
  output logic                       request_ready,
  input  logic                       request_write,
  input  logic [31:0]                request_address,
  input  logic [DMEM_DATA_WIDTH-1:0] request_writeData,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [DMEM_LANES-1:0]      request_byteEnable,
`endif
  output logic                       response_valid,
  output logic [DMEM_DATA_WIDTH-1:0] response_readData,
  output logic                       response_error,
  output logic                       busy
);
  dmemState_t state;
  logic [DMEM_CNT_WIDTH-1:0] count;
  logic writeQ;
  logic [31:0] addrQ;
  logic [DMEM_DATA_WIDTH-1:0] dataQ, ramData;
  logic [DMEM_LANES-1:0] selEnable, ramWrite;
  logic accept, enterRespond, selWrite, selFault, ramRead;
  logic [31:0] selAddr;
  logic [DMEM_DATA_WIDTH-1:0] selData;
`ifdef DMEM_BYTE_ENABLE_EN
  logic [DMEM_LANES-1:0] enableQ;
`endif
  // with zero wait states the RAM is accessed on the accept edge, so it must see the live request
  always_comb begin
    accept = request_valid && request_ready;
    selWrite = state == IDLE ? request_write : writeQ;
    selAddr = state == IDLE ? request_address : addrQ;
    selData = state == IDLE ? request_writeData : dataQ;
`ifdef DMEM_BYTE_ENABLE_EN
    selEnable = state == IDLE ? request_byteEnable : enableQ;
`else
    selEnable = '1;
`endif
    selFault = addrFault(selAddr, ADDR_WIDTH);
    enterRespond = (state == WAIT && count == '0) || (accept && WAIT_STATES == 0);
    ramWrite = {DMEM_LANES{enterRespond && selWrite && !selFault}} & selEnable;
    ramRead = enterRespond && !selWrite && !selFault;
  end
  // response outputs decode the state; data is gated so stores and faults return zero
  always_comb begin
    request_ready = state == IDLE;
    response_valid = state == RESPOND;
    busy = state != IDLE;
    response_error = response_valid && addrFault(addrQ, ADDR_WIDTH);
    response_readData = response_valid && !writeQ && !addrFault(addrQ, ADDR_WIDTH) ? ramData : '0;
  end
  // FSM, wait counter and request latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      writeQ <= 1'b0;
      addrQ <= '0;
      dataQ <= '0;
`ifdef DMEM_BYTE_ENABLE_EN
      enableQ <= '0;
`endif
    end else begin
      state <= state == IDLE ? (accept ? (WAIT_STATES == 0 ? RESPOND : WAIT) : IDLE)
             : state == WAIT ? (count == '0 ? RESPOND : WAIT) : IDLE;
      count <= accept ? DMEM_CNT_WIDTH'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1)
             : (state == WAIT && count != '0) ? count - 1'b1 : count;
      if (accept) begin
        writeQ <= request_write;
        addrQ <= request_address;
        dataQ <= request_writeData;
`ifdef DMEM_BYTE_ENABLE_EN
        enableQ <= request_byteEnable;
`endif
      end
    end
  end
  dmem_storage_array #(.ADDR_WIDTH(ADDR_WIDTH)) storage (
    .clock(clock),
    .writeEnable(ramWrite),
    .readEnable(ramRead),
    .index(selAddr[ADDR_WIDTH+1:2]),
    .writeData(selData),
    .readData(ramData)
  );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for the data-memory responder (WAIT_STATES 2 and 0 instances)
module tb_data_memory_responder;
  localparam int AW = 10;
  localparam int WS = 2;
  logic clock = 0, reset = 0;
  logic reqValid = 0, reqWrite = 0;
  logic [31:0] reqAddr = 0, reqData = 0;
  logic [3:0] reqEnable = 4'hF;
  logic reqReady, rspValid, rspError, isBusy;
  logic [31:0] rspData;
  logic reqValid0 = 0, reqWrite0 = 0;
  logic [31:0] reqAddr0 = 0, reqData0 = 0;
  logic [3:0] reqEnable0 = 4'hF;
  logic reqReady0, rspValid0, rspError0, isBusy0;
  logic [31:0] rspData0;
  int checks = 0, errors = 0;
  logic [32:0] sb [$];
  logic [32:0] popped;
  logic [31:0] model [int];

  always #5 clock = ~clock;

  data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .request_valid(reqValid), .request_ready(reqReady), .request_write(reqWrite),
    .request_address(reqAddr), .request_writeData(reqData),
`ifdef DMEM_BYTE_ENABLE_EN
    .request_byteEnable(reqEnable),
`endif
    .response_valid(rspValid), .response_readData(rspData), .response_error(rspError), .busy(isBusy)
  );

  data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .request_valid(reqValid0), .request_ready(reqReady0), .request_write(reqWrite0),
    .request_address(reqAddr0), .request_writeData(reqData0),
`ifdef DMEM_BYTE_ENABLE_EN
    .request_byteEnable(reqEnable0),
`endif
    .response_valid(rspValid0), .response_readData(rspData0), .response_error(rspError0), .busy(isBusy0)
  );

  always @(negedge clock) begin
    if (reset === 1'b1 && rspValid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response data=%h error=%b with nothing outstanding", rspData, rspError);
      end else begin
        popped = sb.pop_front();
        if ({rspData, rspError} !== popped) begin
          errors++;
          $display("FAIL response got data=%h error=%b expected data=%h error=%b",
                   rspData, rspError, popped[32:1], popped[0]);
        end
      end
    end
  end

  task automatic doReq(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] en);
    logic err;
    int idx, lat;
    logic [31:0] exp, cur;
    err = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 0);
    idx = int'(addr[AW+1:2]);
    exp = 0;
    if (wr && !err) begin
      cur = model.exists(idx) ? model[idx] : 32'd0;
      for (int i = 0; i < 4; i++) if (en[i]) cur[8*i +: 8] = data[8*i +: 8];
      model[idx] = cur;
    end
    if (!wr && !err) exp = model[idx];
    sb.push_back({exp, err});
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1) begin errors++; $display("FAIL ready_before_req got %b expected 1", reqReady); end
    reqValid = 1; reqWrite = wr; reqAddr = addr; reqData = data; reqEnable = en;
    @(posedge clock);
    @(negedge clock);
    reqValid = 0;
    lat = 1;
    checks++;
    if (isBusy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b expected 1", isBusy); end
    while (rspValid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat != WS + 1) begin errors++; $display("FAIL latency got %0d expected %0d", lat, WS + 1); end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", rspValid); end
    checks++; if (isBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", isBusy); end
    checks++; if (rspData !== 32'd0) begin errors++; $display("FAIL reset_data got %h expected 0", rspData); end
    checks++; if (rspError !== 1'b0) begin errors++; $display("FAIL reset_error got %b expected 0", rspError); end
  endtask

  task automatic test_store_load;
    doReq(1, 32'h10, 32'hDEADBEEF, 4'hF);
    doReq(0, 32'h10, 0, 4'hF);
    doReq(1, 32'hFFC, 32'hA5A50F0F, 4'hF);
    doReq(0, 32'hFFC, 0, 4'hF);
    doReq(1, 32'h14, 32'h0BADF00D, 4'hF);
    doReq(0, 32'h14, 0, 4'hF);
  endtask

  task automatic test_errors;
    doReq(0, 32'h13, 0, 4'hF);
    doReq(0, 32'h1000, 0, 4'hF);
    doReq(1, 32'h12, 32'h01020304, 4'hF);
    doReq(1, 32'h80000010, 32'h99999999, 4'hF);
    doReq(0, 32'h10, 0, 4'hF);
  endtask

  task automatic test_byte_enable;
`ifdef DMEM_BYTE_ENABLE_EN
    doReq(1, 32'h20, 32'h11223344, 4'hF);
    doReq(1, 32'h20, 32'hAABBCCDD, 4'b0101);
    doReq(0, 32'h20, 0, 4'hF);
    doReq(1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    doReq(0, 32'h20, 0, 4'hF);
`endif
  endtask

  task automatic test_reset_mid;
    doReq(1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clock);
    reqValid = 1; reqWrite = 1; reqAddr = 32'h30; reqData = 32'h55; reqEnable = 4'hF;
    @(posedge clock);
    @(negedge clock);
    reqValid = 0;
    checks++; if (isBusy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", isBusy); end
    reset = 0;
    #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b expected 1", reqReady); end
    checks++; if (isBusy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b expected 0", isBusy); end
    @(negedge clock);
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (rspValid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse cycle %0d got %b expected 0", k, rspValid); end
    end
    doReq(0, 32'h30, 0, 4'hF);
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    reqValid0 = 1; reqWrite0 = 1; reqAddr0 = 32'h40; reqData0 = 32'h77; reqEnable0 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (reqReady0 !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_ready cycle %0d got %b expected %b", k, reqReady0, k % 2 == 0); end
      checks++;
      if (rspValid0 !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_valid cycle %0d got %b expected %b", k, rspValid0, k % 2 == 1); end
      checks++;
      if (isBusy0 !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_busy cycle %0d got %b expected %b", k, isBusy0, k % 2 == 1); end
      if (k % 2 == 1) begin
        checks++;
        if ({rspData0, rspError0} !== 33'd0) begin errors++; $display("FAIL b2b_store_rsp got data=%h error=%b expected 0/0", rspData0, rspError0); end
      end
      @(negedge clock);
    end
    reqValid0 = 0;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_errors;
    test_byte_enable;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL outstanding got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
